div3_serial: RTL

DIV3_SERIAL -- requirements
Module: div3_serial

---
 rtl/div3_pkg.sv | 15 +
 rtl/div3_step.sv | 26 ++
 rtl/div3_serial.sv | 136 +++++++++++++
 3 files changed

// File: rtl/div3_pkg.sv
// Shared types and constants for the serial divisible-by-3 checker.
// The running remainder only ever holds REM0..REM2. Encoding 2'b11 is unused.
package div3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] REM0 = 2'd0;
    localparam logic [1:0] REM1 = 2'd1;
    localparam logic [1:0] REM2 = 2'd2;

endpackage

// File: rtl/div3_step.sv
// One MSB-first step of a mod-3 reduction.
// Appending a bit to a value with remainder r gives a remainder of
// (2*r + bit) mod 3. The unused encoding 2'b11 maps to REM0.
module div3_step
    import div3_pkg::*;
(
    input  logic [1:0] rem_i,
    input  logic       bit_i,
    output logic [1:0] rem_next_o
);

    // Small lookup table in place of an adder and a modulo.
    always_comb begin
        rem_next_o = REM0;
        case ({rem_i, bit_i})
            {REM0, 1'b0}: rem_next_o = REM0;
            {REM0, 1'b1}: rem_next_o = REM1;
            {REM1, 1'b0}: rem_next_o = REM2;
            {REM1, 1'b1}: rem_next_o = REM0;
            {REM2, 1'b0}: rem_next_o = REM1;
            {REM2, 1'b1}: rem_next_o = REM2;
            default:      rem_next_o = REM0;
        endcase
    end

endmodule

// File: rtl/div3_serial.sv
// Serial divisible-by-3 checker. It shifts in one operand bit per cycle,
// MSB first.
// Optional feature: defining DIV3_REMAINDER_EN adds the out_rem port and
// its output register.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is 1 in IDLE, 0 in SHIFT, and follows out_ready in DONE,
// so a new operand can be accepted on the same edge that retires a result.
// out_valid and the result outputs stay stable until out_ready is sampled high.
//
// Timing: the accept edge loads the operand. The next WIDTH edges each
// consume one bit. One more edge moves the FSM into DONE, so out_valid rises
// WIDTH+1 edges after the accept edge.
module div3_serial
    import div3_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_div,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef DIV3_REMAINDER_EN
    output logic [1:0]       out_rem,
`endif
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [1:0]       rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       rem_step;
    logic             accept;
    logic             bits_done;

    assign accept    = in_valid && in_ready;
    assign bits_done = (cnt_q == CNT_LAST);

    div3_step u_step (
        .rem_i      (rem_q),
        .bit_i      (shreg_q[WIDTH-1]),
        .rem_next_o (rem_step)
    );

    // FSM state register with asynchronous reset to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (bits_done) state_d = DONE;
            DONE:    if (out_ready) state_d = in_valid ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake flags and the divisibility flag.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_div   = 1'b0;
        case (state_q)
            IDLE:  in_ready = 1'b1;
            SHIFT: in_ready = 1'b0;
            DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
                out_div   = (rem_q == REM0);
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath next state: load on accept, otherwise shift one bit per SHIFT cycle.
    always_comb begin
        shreg_d = shreg_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        if (accept) begin
            shreg_d = in_data;
            rem_d   = REM0;
            cnt_d   = '0;
        end else if (state_q == SHIFT && !bits_done) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            rem_d   = rem_step;
            cnt_d   = cnt_q + CW'(1);
        end
    end

    // Datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            rem_q   <= REM0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DIV3_REMAINDER_EN
    logic [1:0] rem_out_q;

    // Remainder output register: holds the final remainder while in DONE, 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_out_q <= REM0;
        end else begin
            rem_out_q <= (state_d == DONE) ? rem_d : REM0;
        end
    end

    assign out_rem = rem_out_q;
`endif

    assign dbg_state_o = state_q;

endmodule
